// File: rtl/smg_scan_param_if.sv
// Bus bundle for the multiplexed 7-segment scan driver.
// The master side is the data producer and the board pins.
// The slave side is the scan driver, smg_scan_param.
//
// Handshake: load is a single-cycle strobe with no back-pressure. In the cycle
// where load=1, digit_data, dp_mask, blank_mask and brightness must be valid.
// Each load is accepted unconditionally.
interface smg_scan_param_if #(
  parameter int NUM_DIGITS = 5,
  parameter int DIM_BITS   = 3
);
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [DIM_BITS-1:0]     brightness;
  logic                    load;
  logic [7:0]              seg_out;
  logic [NUM_DIGITS-1:0]   com_out;
  logic                    frame_done;

  modport master (
    output digit_data, dp_mask, blank_mask, brightness, load,
    input  seg_out, com_out, frame_done
  );

  modport slave (
    input  digit_data, dp_mask, blank_mask, brightness, load,
    output seg_out, com_out, frame_done
  );
endinterface

// File: rtl/smg_scan_param.sv
// Multiplexed 7-segment scan driver.
// Digit 0 is the rightmost digit.
// Features: per-digit decimal point and blanking, PWM brightness, and
// frame-synchronous (tear-free) loading of display data.
// Optional feature macro: LZ_SUPPRESS_EN enables leading-zero suppression.
module smg_scan_param #(
  parameter int NUM_DIGITS     = 5,
  parameter int DIV_PERIOD     = 24000,
  parameter int DIM_BITS       = 3,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int COM_ACTIVE_LOW = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  smg_scan_param_if.slave   bus
);
  localparam int CW = $clog2(DIV_PERIOD);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = DIM_BITS + 33;
  localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] COM_OFF = (COM_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [DIM_BITS-1:0]     pend_bright_q, pend_bright_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;
  logic [DIM_BITS-1:0]     disp_bright_q, disp_bright_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   com_q, com_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   eff_blank;
  logic [NUM_DIGITS-1:0]   sel;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [PW-1:0]           prod;
  logic [PW-1:0]           on_time;
  logic                    lit;
  logic [7:0]              seg_al;

  // Active-low segment code {DP,G,F,E,D,C,B,A}. The DP bit is always off here.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 8'hC0;
      4'h1: hex_to_seg = 8'hF9;
      4'h2: hex_to_seg = 8'hA4;
      4'h3: hex_to_seg = 8'hB0;
      4'h4: hex_to_seg = 8'h99;
      4'h5: hex_to_seg = 8'h92;
      4'h6: hex_to_seg = 8'h82;
      4'h7: hex_to_seg = 8'hF8;
      4'h8: hex_to_seg = 8'h80;
      4'h9: hex_to_seg = 8'h90;
      4'hA: hex_to_seg = 8'h88;
      4'hB: hex_to_seg = 8'h83;
      4'hC: hex_to_seg = 8'hC6;
      4'hD: hex_to_seg = 8'hA1;
      4'hE: hex_to_seg = 8'h86;
      default: hex_to_seg = 8'h8E;
    endcase
  endfunction

  // Divider, scan index, frame pulse, and pending/display register loading.
  always_comb begin
    tick          = (cnt_q == CW'(DIV_PERIOD - 1));
    wrap          = tick && (idx_q == IW'(NUM_DIGITS - 1));
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    idx_d         = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
    frame_done_d  = wrap;
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_bright_d = pend_bright_q;
    pend_valid_d  = pend_valid_q;
    disp_data_d   = disp_data_q;
    disp_dp_d     = disp_dp_q;
    disp_blank_d  = disp_blank_q;
    disp_bright_d = disp_bright_q;
    if (wrap) begin
      // A load that coincides with the wrap bypasses the pending stage.
      if (bus.load) begin
        disp_data_d   = bus.digit_data;
        disp_dp_d     = bus.dp_mask;
        disp_blank_d  = bus.blank_mask;
        disp_bright_d = bus.brightness;
      end else if (pend_valid_q) begin
        disp_data_d   = pend_data_q;
        disp_dp_d     = pend_dp_q;
        disp_blank_d  = pend_blank_q;
        disp_bright_d = pend_bright_q;
      end
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      pend_data_d   = bus.digit_data;
      pend_dp_d     = bus.dp_mask;
      pend_blank_d  = bus.blank_mask;
      pend_bright_d = bus.brightness;
      pend_valid_d  = 1'b1;
    end
  end

`ifdef LZ_SUPPRESS_EN
  logic lz_run;
  // Leading-zero suppression: blank zero digits from the top down until the first non-zero or DP digit.
  always_comb begin
    eff_blank = disp_blank_q;
    lz_run    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lz_run && (disp_data_q[4*i +: 4] == 4'h0) && !disp_dp_q[i]) begin
        eff_blank[i] = 1'b1;
      end else if ((disp_data_q[4*i +: 4] != 4'h0) || disp_dp_q[i]) begin
        lz_run = 1'b0;
      end
    end
  end
`else
  // Without suppression, only the explicit blank mask darkens a digit.
  always_comb begin
    eff_blank = disp_blank_q;
  end
`endif

  // Decode the current digit and apply PWM, blanking and ghost guard to the next output values.
  always_comb begin
    sel       = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel[i]    = 1'b1;
        cur_nib   = disp_data_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = eff_blank[i];
      end
    end
    prod    = (PW'(disp_bright_q) + PW'(1)) * PW'(DIV_PERIOD);
    on_time = prod >> DIM_BITS;
    // The last cycle of a slot stays dark so the output is dark when idx steps.
    lit     = !cur_blank && !tick && (PW'(cnt_q) < on_time);
    seg_al  = cur_blank ? 8'hFF : (hex_to_seg(cur_nib) & {~cur_dp, 7'h7F});
    seg_d   = (SEG_ACTIVE_LOW != 0) ? seg_al : ~seg_al;
    com_d   = COM_OFF;
    if (lit) com_d = (COM_ACTIVE_LOW != 0) ? ~sel : sel;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pend_bright_q <= '0;
      pend_valid_q  <= 1'b0;
      disp_data_q   <= '0;
      disp_dp_q     <= '0;
      disp_blank_q  <= '1;
      disp_bright_q <= '0;
      seg_q         <= SEG_OFF;
      com_q         <= COM_OFF;
      frame_done_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_bright_q <= pend_bright_d;
      pend_valid_q  <= pend_valid_d;
      disp_data_q   <= disp_data_d;
      disp_dp_q     <= disp_dp_d;
      disp_blank_q  <= disp_blank_d;
      disp_bright_q <= disp_bright_d;
      seg_q         <= seg_d;
      com_q         <= com_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.com_out    = com_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_smg_scan_param.sv
// Bench for smg_scan_param with 4 digits, an 8-cycle slot and active-low pins.
// The reference model reasons in frames. A load seen anywhere in frame f
// becomes the display content of frame f+1, and the last load in a frame wins.
// Each output cycle k shows the position k-1 of the scan stream.
module tb_smg_scan_param;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int DB = 3;
  localparam int DN = N * D;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  smg_scan_param_if #(.NUM_DIGITS(N), .DIM_BITS(DB)) bus ();

  smg_scan_param #(
    .NUM_DIGITS(N), .DIV_PERIOD(D), .DIM_BITS(DB),
    .SEG_ACTIVE_LOW(1), .COM_ACTIVE_LOW(1)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int k     = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model state: content shown this frame, and content queued for the next frame.
  logic [15:0] m_data, n_data;
  logic [3:0]  m_dp, n_dp, m_blank, n_blank;
  logic [2:0]  m_br, n_br;
  bit          have_next;
  logic [12:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  // Expected {com, seg} for stream position p under the current frame content.
  function automatic logic [11:0] model_out(input int p);
    int c, d, on;
    logic [3:0] lz;
    logic [3:0] nib;
    logic       bl;
    logic [7:0] s;
    logic [3:0] cm;
    c  = p % D;
    d  = (p / D) % N;
    lz = 4'h0;
`ifdef LZ_SUPPRESS_EN
    begin
      bit run;
      run = 1'b1;
      for (int i = N - 1; i >= 1; i--) begin
        if (m_data[4*i +: 4] != 4'h0 || m_dp[i]) run = 1'b0;
        else if (run) lz[i] = 1'b1;
      end
    end
`endif
    nib = m_data[4*d +: 4];
    bl  = m_blank[d] | lz[d];
    on  = ((int'(m_br) + 1) * D) >> DB;
    s   = bl ? 8'hFF : (seg_tab[nib] & (m_dp[d] ? 8'h7F : 8'hFF));
    cm  = 4'hF;
    if (!bl && c != D - 1 && c < on) cm[d] = 1'b0;
    return {cm, s};
  endfunction

  task automatic do_cycle(input bit ld);
    logic [12:0] e;
    bus.load = ld;
    if (ld) begin
      n_data = bus.digit_data; n_dp = bus.dp_mask;
      n_blank = bus.blank_mask; n_br = bus.brightness;
      have_next = 1'b1;
    end
    exp_q.push_back({((k + 1) % DN == 0), model_out(k)});
    @(posedge clk_in);
    #1;
    k++;
    if (k % DN == 0 && have_next) begin
      m_data = n_data; m_dp = n_dp; m_blank = n_blank; m_br = n_br;
      have_next = 1'b0;
    end
    e = exp_q.pop_front();
    check("seg_out", 32'(bus.seg_out), 32'(e[7:0]));
    check("com_out", 32'(bus.com_out), 32'(e[11:8]));
    check("frame_done", 32'(bus.frame_done), 32'(e[12]));
    bus.load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0);
  endtask

  task automatic run_to(input int pos);
    while (k % DN != pos) do_cycle(1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_in   = 1'b1;
    bus.load = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
    check("rst_seg", 32'(bus.seg_out), 32'h0FF);
    check("rst_com", 32'(bus.com_out), 32'hF);
    check("rst_fd", 32'(bus.frame_done), 32'h0);
    rst_in    = 1'b0;
    k         = 0;
    m_data    = '0; m_dp = '0; m_blank = 4'hF; m_br = '0;
    have_next = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_in(input logic [15:0] dd, input logic [3:0] dp, input logic [3:0] bl, input logic [2:0] br);
    bus.digit_data = dd; bus.dp_mask = dp; bus.blank_mask = bl; bus.brightness = br;
  endtask

  initial begin
    int fd_cnt;
    bus.load = 1'b0;
    set_in(16'h0, 4'h0, 4'h0, 3'h0);

    // Reset held 3 cycles, then two dark frames with a frame pulse every 32 cycles.
    do_reset(3);
    fd_cnt = 0;
    for (int i = 0; i < 2 * DN; i++) begin
      do_cycle(1'b0);
      if (bus.frame_done) fd_cnt++;
    end
    check("fd_count", 32'(fd_cnt), 32'd2);

    // Full brightness, mixed digits.
    set_in(16'h1A3F, 4'h0, 4'h0, 3'd7);
    do_cycle(1'b1);
    run(2 * DN);

    // Dimmest setting.
    set_in(16'h8888, 4'h0, 4'h0, 3'd0);
    do_cycle(1'b1);
    run(2 * DN);

    // Two loads within a frame; only the second should appear.
    run_to(10);
    set_in(16'h2222, 4'h0, 4'h0, 3'd5);
    do_cycle(1'b1);
    run_to(20);
    set_in(16'h4567, 4'h3, 4'h0, 3'd6);
    do_cycle(1'b1);
    run(DN);

    // Load on the wrap cycle goes straight to the display.
    run_to(DN - 1);
    set_in(16'hBCDE, 4'h0, 4'h0, 3'd7);
    do_cycle(1'b1);
    run(DN);

    // Decimal point on a zero digit, and a blanked digit.
    set_in(16'h0007, 4'b0010, 4'b1000, 3'd7);
    do_cycle(1'b1);
    run(2 * DN);

    // Randomized loads at random points, some on the wrap cycle.
    for (int r = 0; r < 40; r++) begin
      run($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) run_to(DN - 1);
      set_in(16'($urandom()), 4'($urandom()),
             4'($urandom_range(0, 15) & $urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      do_cycle(1'b1);
    end
    run(2 * DN);

    // Reset mid-slot with a pending load; the pending data must never show.
    run_to(13);
    set_in(16'h9999, 4'h0, 4'h0, 3'd7);
    do_cycle(1'b1);
    run(3);
    do_reset(1);
    run(2 * DN);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
